button_debouncer: RTL and testbench

Synchronizes and debounces a raw, asynchronous, bouncy push-button input into a clean one-bit `level`. It sits directly upstream of the level-to-pulse converter, whose `level` input it drives. Each qualified press therefore yields exactly one converter pulse. It also counts rejected bounces (glitches) for bring-up visibility.

---
 rtl/button_debouncer.sv | 124 ++++++++++++
 tb/tb_button_debouncer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a four-state qualification FSM that turns a bouncy
// push-button into a clean registered level and counts rejected bounces.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       level,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    StIdleLow,
    StWaitHigh,
    StIdleHigh,
    StWaitLow
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    abort   = 1'b0;
    unique case (state_q)
      StIdleLow: begin
        if (sync2_q) begin
          state_d = StWaitHigh;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitHigh: begin
        if (!sync2_q) begin
          state_d = StIdleLow;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleHigh;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StIdleHigh: begin
        if (!sync2_q) begin
          state_d = StWaitLow;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitLow: begin
        if (sync2_q) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLow;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturate rather than wrap so a noisy button never looks clean again.
  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_comb begin
    busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= StIdleLow;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign level      = level_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: each driven cycle pushes the expected post-edge outputs from a run-length
// model; a checker pops and compares just after every rising edge.
module tb_button_debouncer;

  localparam int unsigned Stable = 4;

  typedef struct packed {
    logic       level;
    logic       busy;
    logic [7:0] glitch;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw = 1'b0;
  logic       level;
  logic       busy;
  logic [7:0] glitch_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model: sync pipeline plus run length of samples disagreeing with the level.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_level = 1'b0;
  int   m_run = 0;
  int   m_glitch = 0;

  button_debouncer #(
    .STABLE_CYCLES(Stable),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw),
    .level     (level),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("sb_level", 32'(level), 32'(e.level));
      check_eq("sb_busy", 32'(busy), 32'(e.busy));
      check_eq("sb_glitch", 32'(glitch_cnt), 32'(e.glitch));
    end
  end

  // Drive one cycle, predict the outputs after the next edge, then wait past that edge.
  task automatic step(input logic r, input logic rst);
    logic s;
    exp_t e;
    @(negedge clk);
    raw   = r;
    reset = rst;
    if (rst) begin
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_run    = 0;
      m_level  = 1'b0;
      m_glitch = 0;
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = r;
      if (s == m_level) begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == int'(Stable)) begin
          m_level = s;
          m_run   = 0;
        end
      end
    end
    e.level  = m_level;
    e.busy   = (m_run > 0);
    e.glitch = 8'(m_glitch);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_glitch"}, 32'(glitch_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_hi;
    int rises;
    int drops;
    logic prev;

    // 1: reset with raw high, then a full rise qualification from scratch
    step(1'b1, 1'b1);
    check_zero("t1_reset");
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0);
      check_eq("t1_level", 32'(level), 32'(j >= 5));
    end

    // 2: clean press from idle low
    step(1'b0, 1'b1);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0);
    busy_hi = 0;
    rises   = 0;
    prev    = level;
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 1'b0);
      check_eq("t2_level", 32'(level), 32'(j >= 5));
      if (busy) busy_hi++;
      if (level && !prev) rises++;
      prev = level;
    end
    check_eq("t2_busy_cycles", 32'(busy_hi), 32'd3);
    check_eq("t2_one_pulse", 32'(rises), 32'd1);
    check_eq("t2_glitch", 32'(glitch_cnt), 32'd0);

    // 4: 3-cycle low bounce is rejected, then a clean release
    drops = 0;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0);
      if (!level) drops++;
    end
    for (int j = 0; j < 10; j++) begin
      step(1'b1, 1'b0);
      if (!level) drops++;
    end
    check_eq("t4_bounce_level", 32'(drops), 32'd0);
    check_eq("t4_bounce_glitch", 32'(glitch_cnt), 32'd1);
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0);
      check_eq("t4_release_level", 32'(level), 32'(j < 5));
    end
    check_eq("t4_glitch_after", 32'(glitch_cnt), 32'd1);

    // 3: two short high bounces never change the level
    step(1'b0, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    rises = 0;
    for (int j = 0; j < 12; j++) begin
      step((j < 2) || (j == 5), 1'b0);
      if (level) rises++;
    end
    check_eq("t3_level", 32'(rises), 32'd0);
    check_eq("t3_glitch", 32'(glitch_cnt), 32'd2);

    // 5: glitch counter saturates
    step(1'b0, 1'b1);
    for (int b = 0; b < 300; b++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    check_eq("t5_sat", 32'(glitch_cnt), 32'd255);
    for (int b = 0; b < 5; b++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    check_eq("t5_hold", 32'(glitch_cnt), 32'd255);
    check_eq("t5_level", 32'(level), 32'd0);

    // 6: reset while qualifying a rise, raw kept high
    step(1'b0, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    for (int j = 0; j < 4; j++) step(1'b1, 1'b0);
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    step(1'b1, 1'b1);
    check_zero("t6_reset");
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b0);
      check_eq("t6_level", 32'(level), 32'(j >= 5));
    end

    @(posedge clk);
    #3;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
